// File: rtl/mips_lsu_bus.sv
// Load/store unit bus adapter: turns one byte/half/word load or store into a single
// aligned bus read or write with lane enables, plus a one-cycle completion pulse.
module mips_lsu_bus (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic        cmd_signed,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_WR,
        S_RD,
        S_RD_DATA,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [31:2] addr_q;
    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        misaligned;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_shift;
    logic [31:0] wdata_nxt;
    logic [31:0] lane_data;
    logic [31:0] load_ext;
    logic        accept;

    assign accept = (state == S_IDLE) && cmd_valid;

    // NOTE: every variable in an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        misaligned = 1'b0;
        be_nxt     = 4'b1111;
        unique case (cmd_size)
            2'b00: begin
                misaligned = 1'b0;
                be_nxt     = 4'b0001 << cmd_addr[1:0];
            end
            2'b01: begin
                misaligned = cmd_addr[0];
                be_nxt     = cmd_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                misaligned = |cmd_addr[1:0];
                be_nxt     = 4'b1111;
            end
            default: begin
                misaligned = 1'b1;
                be_nxt     = 4'b0000;
            end
        endcase
    end

    // Store data moves up to its byte lane; lanes not enabled are forced to zero, and loads drive nothing.
    always_comb begin
        wdata_shift = cmd_wdata << {cmd_addr[1:0], 3'b000};
        wdata_nxt   = '0;
        for (int k = 0; k < 4; k++) begin
            if (be_nxt[k] && cmd_write)
                wdata_nxt[8*k +: 8] = wdata_shift[8*k +: 8];
        end
    end

    always_comb begin
        lane_data = readdata >> {lo_q, 3'b000};
        load_ext  = readdata;
        unique case (size_q)
            2'b00:   load_ext = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_ext = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
            default: load_ext = readdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            lo_q     <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                addr_q   <= cmd_addr[31:2];
                lo_q     <= cmd_addr[1:0];
                size_q   <= cmd_size;
                signed_q <= cmd_signed;
                write_q  <= cmd_write;
                be_q     <= be_nxt;
                wdata_q  <= wdata_nxt;
            end
            // The responder's data is valid on the edge that leaves RD_DATA.
            if (state == S_RD_DATA)
                rdata_q <= load_ext;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (misaligned)     state_nxt = S_ERR;
                    else if (cmd_write) state_nxt = S_WR;
                    else                state_nxt = S_RD;
                end
            end
            S_ERR:     state_nxt = S_IDLE;
            S_WR:      if (!waitrequest) state_nxt = S_RESP;
            S_RD:      if (!waitrequest) state_nxt = S_RD_DATA;
            S_RD_DATA: state_nxt = S_RESP;
            S_RESP:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        cmd_ready  = (state == S_IDLE);
        read       = (state == S_RD);
        write      = (state == S_WR);
        rsp_valid  = (state == S_RESP) || (state == S_ERR);
        rsp_error  = (state == S_ERR);
        rsp_rdata  = ((state == S_RESP) && !write_q) ? rdata_q : 32'h0;
        address    = {addr_q, 2'b00};
        byteenable = be_q;
        writedata  = wdata_q;
    end

endmodule
